// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: turns hazard, branch, memory-wait and multicycle-issue
// flags into freeze/flush/bubble controls for the IF/ID, ID/EXE and EXE/MEM registers.
// Holds the multicycle-EXE FSM and its down-counter.
// Optional macro STALL_PERF_EN adds a saturating 32-bit Stall_Cycles counter output.
module pipeline_stall_controller #(
  parameter int unsigned MULTI_CYCLES = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Hazard_Detected,
  input  logic        Branch_Taken,
  input  logic        Multi_Start,
  input  logic        Mem_Req,
  input  logic        Mem_Ready,
  output logic        Freeze_IF,
  output logic        Freeze_ID,
  output logic        Flush_IF,
  output logic        Flush_ID,
  output logic        Freeze_EXE,
  output logic        Bubble_MEM,
  output logic        Freeze_MEM,
`ifdef STALL_PERF_EN
  output logic [31:0] Stall_Cycles,
`endif
  output logic        Multi_Busy
);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StMulti = 1'b1;

  localparam logic             MultiEn = (MULTI_CYCLES > 1);
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULTI_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;

  assign mem_wait   = Mem_Req & ~Mem_Ready;
  assign Multi_Busy = rst_n & (state_q == StMulti);

  // Next-state: memory wait freezes the FSM; MULTI counts down; RUN may launch a multicycle op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      if (state_q == StMulti) begin
        // cnt==0 in MULTI is unreachable; treat it like the last cycle for robustness
        if (cnt_q <= CntOne) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end else if (!Branch_Taken && !Hazard_Detected && Multi_Start && MultiEn) begin
        state_d = StMulti;
        cnt_d   = CntLoad;
      end
    end
  end

  // State register with asynchronous reset to RUN, counter cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage controls by fixed priority; everything is forced low while reset is held.
  always_comb begin
    Freeze_IF  = 1'b0;
    Freeze_ID  = 1'b0;
    Flush_IF   = 1'b0;
    Flush_ID   = 1'b0;
    Freeze_EXE = 1'b0;
    Bubble_MEM = 1'b0;
    Freeze_MEM = 1'b0;
    if (!rst_n) begin
      Freeze_IF = 1'b0;
    end else if (mem_wait) begin
      Freeze_IF  = 1'b1;
      Freeze_ID  = 1'b1;
      Freeze_EXE = 1'b1;
      Freeze_MEM = 1'b1;
    end else if (state_q == StMulti) begin
      Freeze_IF  = 1'b1;
      Freeze_ID  = 1'b1;
      Freeze_EXE = 1'b1;
      Bubble_MEM = 1'b1;
    end else if (Branch_Taken) begin
      Flush_IF = 1'b1;
      Flush_ID = 1'b1;
    end else if (Hazard_Detected) begin
      Freeze_IF = 1'b1;
      Freeze_ID = 1'b1;
      Flush_ID  = 1'b1;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_q;

  // Count front-end stall cycles, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (Freeze_IF && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign Stall_Cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed table-driven bench for pipeline_stall_controller (MULTI_CYCLES=3).
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic hz, br, ms, mreq, mrdy;
  logic f_if, f_id, fl_if, fl_id, f_exe, b_mem, f_mem, busy;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .MULTI_CYCLES(3),
    .CNT_W       (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Hazard_Detected(hz),
    .Branch_Taken   (br),
    .Multi_Start    (ms),
    .Mem_Req        (mreq),
    .Mem_Ready      (mrdy),
    .Freeze_IF      (f_if),
    .Freeze_ID      (f_id),
    .Flush_IF       (fl_if),
    .Flush_ID       (fl_id),
    .Freeze_EXE     (f_exe),
    .Bubble_MEM     (b_mem),
    .Freeze_MEM     (f_mem),
`ifdef STALL_PERF_EN
    .Stall_Cycles   (stall_cycles),
`endif
    .Multi_Busy     (busy)
  );

  // Output packing: {Freeze_IF, Freeze_ID, Flush_IF, Flush_ID, Freeze_EXE, Bubble_MEM,
  // Freeze_MEM, Multi_Busy}
  localparam logic [7:0] E0   = 8'b0000_0000;
  localparam logic [7:0] EHZ  = 8'b1101_0000;
  localparam logic [7:0] EBR  = 8'b0011_0000;
  localparam logic [7:0] EMU  = 8'b1100_1101;
  localparam logic [7:0] EMWR = 8'b1100_1010;
  localparam logic [7:0] EMWM = 8'b1100_1011;

  // Input packing: {Hazard_Detected, Branch_Taken, Multi_Start, Mem_Req, Mem_Ready}
  typedef struct {
    logic [4:0] in;
    logic [7:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_stall = 0;

  function automatic logic [7:0] outs();
    return {f_if, f_id, fl_if, fl_id, f_exe, b_mem, f_mem, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {hz, br, ms, mreq, mrdy} = in;
  endtask

  task automatic check_stall(input string name);
`ifdef STALL_PERF_EN
    check(name, stall_cycles, exp_stall);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v[$];
    string nm;
    v.push_back('{5'b00000, E0});    // 0 idle
    v.push_back('{5'b10000, EHZ});   // 1 hazard
    v.push_back('{5'b10000, EHZ});   // 2 hazard again
    v.push_back('{5'b00000, E0});    // 3
    v.push_back('{5'b00100, E0});    // 4 multi issue
    v.push_back('{5'b00000, EMU});   // 5 MULTI cnt=2
    v.push_back('{5'b00000, EMU});   // 6 MULTI cnt=1
    v.push_back('{5'b00000, E0});    // 7 back in RUN
    v.push_back('{5'b01100, EBR});   // 8 branch beats multi
    v.push_back('{5'b00000, E0});    // 9 stayed RUN
    v.push_back('{5'b10100, EHZ});   // 10 hazard beats multi
    v.push_back('{5'b00000, E0});    // 11 stayed RUN
    v.push_back('{5'b00100, E0});    // 12 multi issue
    v.push_back('{5'b00010, EMWM});  // 13 mem wait in MULTI, cnt held
    v.push_back('{5'b00010, EMWM});  // 14
    v.push_back('{5'b00010, EMWM});  // 15
    v.push_back('{5'b00011, EMU});   // 16 mem ready, MULTI cnt=2
    v.push_back('{5'b00000, EMU});   // 17 MULTI cnt=1
    v.push_back('{5'b00000, E0});    // 18 RUN
    v.push_back('{5'b01010, EMWR});  // 19 branch during mem wait: no flush
    v.push_back('{5'b01011, EBR});   // 20 mem ready: branch acts
    v.push_back('{5'b11000, EBR});   // 21 branch beats hazard
    v.push_back('{5'b00011, E0});    // 22 completed access
    v.push_back('{5'b00110, EMWR});  // 23 multi issue blocked by mem wait
    v.push_back('{5'b00000, E0});    // 24 did not enter MULTI
    v.push_back('{5'b00100, E0});    // 25 multi issue
    v.push_back('{5'b11000, EMU});   // 26 hazard/branch ignored in MULTI
    v.push_back('{5'b00100, EMU});   // 27 multi start ignored in MULTI
    v.push_back('{5'b00000, E0});    // 28 RUN, no re-entry

    // Reset held while inputs toggle: outputs must stay low.
    rst_n = 1'b0;
    drive(5'b00000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 drive(5'($urandom_range(0, 31)));
      @(negedge clk);
      check($sformatf("reset_outs%0d", i), 32'(outs()), 32'(E0));
    end
    check_stall("reset_stall");
    @(posedge clk);
    #1 drive(5'b00000);
    #2 rst_n = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      @(posedge clk);
      #1 drive(v[i].in);
      @(negedge clk);
      nm = $sformatf("vec%0d", i);
      check(nm, 32'(outs()), 32'(v[i].exp));
      check_stall({nm, "_stall"});
      if (v[i].exp[7]) exp_stall = exp_stall + 1;
    end

    // Async reset while in MULTI: state clears without a clock edge.
    @(posedge clk);
    #1 drive(5'b00100);
    @(posedge clk);
    if (v[v.size()-1].exp[7]) exp_stall = exp_stall + 0;
    #1 drive(5'b00000);
    #1 check("multi_before_reset", 32'(outs()), 32'(EMU));
    #1 rst_n = 1'b0;
    #1 check("async_reset_outs", 32'(outs()), 32'(E0));
    exp_stall = 0;
    check_stall("async_reset_stall");
    #1 rst_n = 1'b1;
    #1 check("after_reset_run", 32'(outs()), 32'(E0));
    @(posedge clk);
    #1 check("after_reset_next", 32'(outs()), 32'(E0));
    check_stall("after_reset_stall");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the hazard-detect flag, the EXE branch-taken flag, the memory-stage wait handshake and a multicycle-op issue flag.
- Turns these into per-stage freeze, flush and bubble controls for the IF/ID, ID/EXE and EXE/MEM pipeline registers.
- Owns the only sequential stall state in the core: a multicycle-EXE FSM with cycle counter, and an optional stall performance counter.
- Sits between the hazard detector / branch logic and the pipeline register enables.

Parameters:
- MULTI_CYCLES, 3: total EXE cycles for a multicycle (min/max) op; legal range 1..15. A value of 1 means the FSM never leaves RUN.
- CNT_W, 4: width of the multicycle down-counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Hazard_Detected  in  1  RAW hazard flag from the hazard detector
- Branch_Taken  in  1  branch resolved taken in EXE
- Multi_Start  in  1  instruction in ID is a multicycle op and issues this cycle
- Mem_Req  in  1  MEM-stage instruction accesses memory
- Mem_Ready  in  1  memory access completes this cycle
- Freeze_IF  out  1  hold PC and IF/ID register
- Freeze_ID  out  1  hold ID/EXE source fields (front-end hold)
- Flush_IF  out  1  load NOP into IF/ID
- Flush_ID  out  1  load NOP into ID/EXE (bubble)
- Freeze_EXE  out  1  hold ID/EXE register contents
- Bubble_MEM  out  1  load NOP into EXE/MEM
- Freeze_MEM  out  1  hold EXE/MEM and MEM/WB registers
- Multi_Busy  out  1  FSM in MULTI state

Behaviour:
- State: FSM {RUN, MULTI} plus counter cnt[CNT_W-1:0]. On rst_n low, asynchronously: state=RUN, cnt=0.
- All outputs are combinational from state, cnt and inputs. With rst_n low, or with all inputs 0 in RUN, every output is 0.
- Priority, highest first, evaluated every cycle:
- 1) Mem wait (Mem_Req & !Mem_Ready), any state: Freeze_IF=Freeze_ID=Freeze_EXE=Freeze_MEM=1; all flush/bubble=0. FSM state and cnt frozen. Branch_Taken, Hazard_Detected and Multi_Start are ignored.
- 2) State MULTI: Freeze_IF=Freeze_ID=Freeze_EXE=1, Bubble_MEM=1. cnt decrements each cycle. When cnt==1 the next state is RUN and cnt becomes 0. Hazard_Detected, Branch_Taken and Multi_Start are ignored.
- 3) RUN & Branch_Taken: Flush_IF=1, Flush_ID=1, no freezes. Multi_Start and Hazard_Detected are ignored because the flushed instruction is discarded.
- 4) RUN & Hazard_Detected: Freeze_IF=Freeze_ID=1, Flush_ID=1. No FSM change. Multi_Start is ignored, so the op re-issues later.
- 5) RUN & Multi_Start & MULTI_CYCLES>1: outputs all 0 (the op advances into EXE). Next state=MULTI, cnt=MULTI_CYCLES-1.
- 6) Otherwise all outputs are 0.
- Latency: a multicycle op blocks the front end for exactly MULTI_CYCLES-1 cycles following its issue cycle, plus any mem-wait cycles interleaved. Mem-wait cycles do not consume cnt.
- Multi_Busy = (state==MULTI).
- X on inputs during reset must not propagate into state.

Optional Feature:
- Macro STALL_PERF_EN.
- Defined: adds output Stall_Cycles, 32 bits. It resets to 0 asynchronously and increments by 1 on every rising edge where Freeze_IF==1. It saturates at 32'hFFFF_FFFF and does not wrap.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset with inputs toggling, then release in RUN with inputs 0 -> all outputs 0, Multi_Busy=0 (and Stall_Cycles=0 when STALL_PERF_EN is defined).
- Hazard_Detected=1 for 2 cycles in RUN -> Freeze_IF=Freeze_ID=Flush_ID=1 in both cycles; FSM stays RUN; Stall_Cycles=2.
- Multi_Start=1 for 1 cycle, MULTI_CYCLES=3 -> issue cycle outputs 0; next 2 cycles Multi_Busy=1, Freeze_IF=Freeze_EXE=Bubble_MEM=1; third cycle back in RUN with outputs 0.
- Multi_Start with Branch_Taken=1 in the same cycle -> Flush_IF=Flush_ID=1, FSM stays RUN. Repeat with Hazard_Detected=1 instead of Branch_Taken -> hazard outputs, FSM stays RUN.
- MULTI entered with cnt=2; on the next cycle Mem_Req=1, Mem_Ready=0 for 3 cycles -> all four freezes=1, Bubble_MEM=0, cnt held at 2; MULTI then completes 2 further cycles after Mem_Ready=1.
- Branch_Taken=1 during a mem wait -> no flush asserted. Assert rst_n low while in MULTI -> state=RUN and cnt=0 immediately, without waiting for a clock edge.
